// File: rtl/vgpr_busy_table_ctrl_pkg.sv
// Shared definitions for the VGPR busy-table controller.
// Holds the VGPR file geometry, the flush sweep chunk size, the flush FSM
// state encodings and a helper that sizes one sweep step.
package vgpr_busy_table_ctrl_pkg;

   localparam int NUMBER_VGPR      = 1024;
   localparam int VGPR_ADDR_LENGTH = 10;
   localparam int ADDR_W           = VGPR_ADDR_LENGTH;
   localparam int REM_W            = ADDR_W + 1;
   localparam int MAX_WORDS        = 4;
   localparam int SWEEP_CHUNK      = 64;
   localparam int CHUNK_W          = $clog2(SWEEP_CHUNK) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } flush_state_t;

   // Number of VGPRs cleared in the current sweep step: min(rem, SWEEP_CHUNK).
   function automatic logic [CHUNK_W-1:0] chunk_len(input logic [REM_W-1:0] rem);
      if (rem >= REM_W'(SWEEP_CHUNK))
         return CHUNK_W'(SWEEP_CHUNK);
      else
         return rem[CHUNK_W-1:0];
   endfunction

endpackage

// File: rtl/vgpr_busy_table_ctrl_range_mask.sv
// Operand decoder: turns (first VGPR, word mask) into a NUMBER_VGPR-bit mask.
// Ports:
//   i_addr  - first VGPR of the operand
//   i_words - per-word valid mask; bit k selects VGPR (i_addr+k) mod NUMBER_VGPR
//   o_mask  - one bit per physical VGPR
module vgpr_range_mask
   import vgpr_busy_table_ctrl_pkg::*;
(
   input  logic [ADDR_W-1:0]      i_addr,
   input  logic [MAX_WORDS-1:0]   i_words,
   output logic [NUMBER_VGPR-1:0] o_mask
);

   always_comb begin
      o_mask = '0;
      for (int k = 0; k < MAX_WORDS; k++) begin
         // ADDR_W-bit sum wraps naturally at the top of the file
         if (i_words[k])
            o_mask[i_addr + ADDR_W'(k)] = 1'b1;
      end
   end

endmodule

// File: rtl/vgpr_busy_table_ctrl.sv
// VGPR busy-table (scoreboard) controller.
// Tracks one busy bit per physical VGPR: issue sets bits, ALU/LSU retire
// clears them, issue gets a registered 4-operand hazard answer, and the
// wavefront dispatcher can free a VGPR range with a multi-cycle flush sweep.
// Ports:
//   clk, rst (async, active-low)
//   set_*      - destination allocation from issue (set_ready: accepted)
//   alu_clr_*  - ALU writeback clear
//   lsu_clr_*  - LSU writeback clear
//   chk_*      - hazard check request / registered response
//   flush_*    - range flush request / ready / completion pulse
//   busy_any   - registered OR of all busy bits
//
// Flush FSM:
//   state    | meaning
//   ST_IDLE  | accepting sets and flush requests
//   ST_SWEEP | clearing up to SWEEP_CHUNK VGPRs per cycle from r_ptr
//   ST_DONE  | flush_ack high for one cycle, then back to idle
module vgpr_busy_table_ctrl
   import vgpr_busy_table_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   set_valid,
   input  logic [ADDR_W-1:0]      set_addr,
   input  logic [MAX_WORDS-1:0]   set_words,
   output logic                   set_ready,
   input  logic                   alu_clr_valid,
   input  logic [ADDR_W-1:0]      alu_clr_addr,
   input  logic [MAX_WORDS-1:0]   alu_clr_words,
   input  logic                   lsu_clr_valid,
   input  logic [ADDR_W-1:0]      lsu_clr_addr,
   input  logic [MAX_WORDS-1:0]   lsu_clr_words,
   input  logic                   chk_valid,
   input  logic [4*ADDR_W-1:0]    chk_addr,
   input  logic [4*MAX_WORDS-1:0] chk_words,
   output logic                   chk_resp_valid,
   output logic [3:0]             chk_busy_vec,
   output logic                   chk_busy,
   input  logic                   flush_req,
   input  logic [ADDR_W-1:0]      flush_base,
   input  logic [REM_W-1:0]       flush_size,
   output logic                   flush_ready,
   output logic                   flush_ack,
   output logic                   busy_any
);

   logic [NUMBER_VGPR-1:0] r_busy;
   logic [NUMBER_VGPR-1:0] w_busy_next;
   logic [NUMBER_VGPR-1:0] w_set_mask;
   logic [NUMBER_VGPR-1:0] w_alu_mask;
   logic [NUMBER_VGPR-1:0] w_lsu_mask;
   logic [NUMBER_VGPR-1:0] w_sweep_mask;
   logic [NUMBER_VGPR-1:0] w_chk_mask [4];
   logic [3:0]             w_chk_hit;

   flush_state_t           r_state;
   logic [ADDR_W-1:0]      r_ptr;
   logic [REM_W-1:0]       r_rem;
   logic [CHUNK_W-1:0]     w_chunk;
   logic [REM_W-1:0]       w_size_clamped;
   logic                   r_set_ready;
   logic                   r_flush_ready;
   logic                   r_flush_ack;
   logic                   r_chk_resp_valid;
   logic [3:0]             r_chk_busy_vec;
   logic                   r_chk_busy;
   logic                   r_busy_any;
   logic                   w_set_fire;

   assign w_set_fire = set_valid & r_set_ready;

   vgpr_range_mask u_set_mask (
      .i_addr  (set_addr),
      .i_words (set_words & {MAX_WORDS{w_set_fire}}),
      .o_mask  (w_set_mask)
   );

   vgpr_range_mask u_alu_mask (
      .i_addr  (alu_clr_addr),
      .i_words (alu_clr_words & {MAX_WORDS{alu_clr_valid}}),
      .o_mask  (w_alu_mask)
   );

   vgpr_range_mask u_lsu_mask (
      .i_addr  (lsu_clr_addr),
      .i_words (lsu_clr_words & {MAX_WORDS{lsu_clr_valid}}),
      .o_mask  (w_lsu_mask)
   );

   for (genvar g = 0; g < 4; g++) begin : g_chk
      vgpr_range_mask u_chk_mask (
         .i_addr  (chk_addr[g*ADDR_W +: ADDR_W]),
         .i_words (chk_words[g*MAX_WORDS +: MAX_WORDS] & {MAX_WORDS{chk_valid}}),
         .o_mask  (w_chk_mask[g])
      );
   end

   assign w_chunk        = chunk_len(r_rem);
   assign w_size_clamped = (flush_size > REM_W'(NUMBER_VGPR)) ? REM_W'(NUMBER_VGPR) : flush_size;

   always_comb begin
      w_sweep_mask = '0;
      if (r_state == ST_SWEEP) begin
         for (int j = 0; j < SWEEP_CHUNK; j++) begin
            if (CHUNK_W'(j) < w_chunk)
               w_sweep_mask[r_ptr + ADDR_W'(j)] = 1'b1;
         end
      end
   end

   // Set is OR-ed last so a new writer keeps the bit against a same-cycle clear.
   assign w_busy_next = (r_busy & ~w_alu_mask & ~w_lsu_mask & ~w_sweep_mask) | w_set_mask;

   always_comb begin
      w_chk_hit = '0;
      for (int i = 0; i < 4; i++)
         w_chk_hit[i] = |(w_chk_mask[i] & w_busy_next);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy           <= '0;
         r_busy_any       <= 1'b0;
         r_chk_resp_valid <= 1'b0;
         r_chk_busy_vec   <= '0;
         r_chk_busy       <= 1'b0;
      end else begin
         r_busy           <= w_busy_next;
         r_busy_any       <= |w_busy_next;
         r_chk_resp_valid <= chk_valid;
         if (chk_valid) begin
            r_chk_busy_vec <= w_chk_hit;
            r_chk_busy     <= |w_chk_hit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_ptr         <= '0;
         r_rem         <= '0;
         r_set_ready   <= 1'b1;
         r_flush_ready <= 1'b1;
         r_flush_ack   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_flush_ack <= 1'b0;
               if (flush_req) begin
                  r_ptr         <= flush_base;
                  r_rem         <= w_size_clamped;
                  r_set_ready   <= 1'b0;
                  r_flush_ready <= 1'b0;
                  if (w_size_clamped == '0) begin
                     r_state     <= ST_DONE;
                     r_flush_ack <= 1'b1;
                  end else begin
                     r_state <= ST_SWEEP;
                  end
               end
            end
            ST_SWEEP: begin
               r_ptr <= r_ptr + ADDR_W'(SWEEP_CHUNK);
               r_rem <= r_rem - REM_W'(w_chunk);
               if (r_rem == REM_W'(w_chunk)) begin
                  r_state     <= ST_DONE;
                  r_flush_ack <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state       <= ST_IDLE;
               r_flush_ack   <= 1'b0;
               r_set_ready   <= 1'b1;
               r_flush_ready <= 1'b1;
            end
            default: begin
               r_state       <= ST_IDLE;
               r_flush_ack   <= 1'b0;
               r_set_ready   <= 1'b1;
               r_flush_ready <= 1'b1;
            end
         endcase
      end
   end

   assign set_ready      = r_set_ready;
   assign flush_ready    = r_flush_ready;
   assign flush_ack      = r_flush_ack;
   assign chk_resp_valid = r_chk_resp_valid;
   assign chk_busy_vec   = r_chk_busy_vec;
   assign chk_busy       = r_chk_busy;
   assign busy_any       = r_busy_any;

endmodule
